// File: rtl/stopwatch_top.sv
`timescale 1ns/1ps
// Six-digit MM.SS.cc stopwatch with debounced buttons and a multiplexed 7-segment driver.
// Latency: display outputs registered, one clock after a scan or digit change; press ~DEBOUNCE+2 cycles.
// Backpressure: none; free-running datapath, button presses are single-cycle pulses.

// Button conditioner: 2-FF synchronizer, debounce, falling-edge press pulse.
module stopwatch_btn #(
    parameter int DEBOUNCE = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [DW-1:0] r_cnt;

    // Bring the asynchronous button level into the clk domain (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == DW'(DEBOUNCE - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_level_d & ~r_level;
endmodule

module stopwatch_top #(
    parameter int TICK_DIV = 1_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int DEBOUNCE = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Clear,
    input  logic       start_stop,
    output logic [5:0] sm_bit,
    output logic [7:0] sm_seg
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic          w_clr_press;
    logic          w_ss_press;
    logic          w_tick;
    logic          r_running;
    logic [TW-1:0] r_presc;
    logic [3:0]    r_c0, r_c1, r_s0, r_s1, r_m0, r_m1;
    logic [SW-1:0] r_scan_cnt;
    logic [2:0]    r_scan_idx;
    logic [3:0]    w_digit;
    logic          w_dp_n;
    logic [5:0]    w_sel;
    logic [6:0]    w_seg;

    stopwatch_btn #(.DEBOUNCE(DEBOUNCE)) u_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (Clear),
        .o_press (w_clr_press)
    );

    stopwatch_btn #(.DEBOUNCE(DEBOUNCE)) u_ss (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (start_stop),
        .o_press (w_ss_press)
    );

    assign w_tick = r_running && (r_presc == TW'(TICK_DIV - 1));

    // Run state and 10 ms prescaler; Clear overrides a simultaneous start/stop press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
            r_presc   <= '0;
        end else if (w_clr_press) begin
            r_running <= 1'b0;
            r_presc   <= '0;
        end else begin
            if (w_ss_press) begin
                r_running <= ~r_running;
            end
            if (r_running) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
        end
    end

    // BCD time counters with ripple carry; 59.59.99 rolls over to 00.00.00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_m1, r_m0, r_s1, r_s0, r_c1, r_c0} <= '0;
        end else if (w_clr_press) begin
            {r_m1, r_m0, r_s1, r_s0, r_c1, r_c0} <= '0;
        end else if (w_tick) begin
            if (r_c0 != 4'd9) begin
                r_c0 <= r_c0 + 4'd1;
            end else begin
                r_c0 <= 4'd0;
                if (r_c1 != 4'd9) begin
                    r_c1 <= r_c1 + 4'd1;
                end else begin
                    r_c1 <= 4'd0;
                    if (r_s0 != 4'd9) begin
                        r_s0 <= r_s0 + 4'd1;
                    end else begin
                        r_s0 <= 4'd0;
                        if (r_s1 != 4'd5) begin
                            r_s1 <= r_s1 + 4'd1;
                        end else begin
                            r_s1 <= 4'd0;
                            if (r_m0 != 4'd9) begin
                                r_m0 <= r_m0 + 4'd1;
                            end else begin
                                r_m0 <= 4'd0;
                                if (r_m1 != 4'd5) begin
                                    r_m1 <= r_m1 + 4'd1;
                                end else begin
                                    r_m1 <= 4'd0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Digit scan: hold each digit for SCAN_DIV cycles, index 0..5 wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 3'd0;
        end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == 3'd5) ? 3'd0 : r_scan_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Select the scanned digit, its decimal point and enable, and decode segments.
    always_comb begin
        w_digit = 4'hF;
        w_dp_n  = 1'b1;
        w_sel   = 6'b000001 << r_scan_idx;
        case (r_scan_idx)
            3'd0: w_digit = r_c0;
            3'd1: w_digit = r_c1;
            3'd2: begin w_digit = r_s0; w_dp_n = 1'b0; end
            3'd3: w_digit = r_s1;
            3'd4: begin w_digit = r_m0; w_dp_n = 1'b0; end
            3'd5: w_digit = r_m1;
            default: w_digit = 4'hF;
        endcase
        case (w_digit)
            4'd0: w_seg = 7'h40;
            4'd1: w_seg = 7'h79;
            4'd2: w_seg = 7'h24;
            4'd3: w_seg = 7'h30;
            4'd4: w_seg = 7'h19;
            4'd5: w_seg = 7'h12;
            4'd6: w_seg = 7'h02;
            4'd7: w_seg = 7'h78;
            4'd8: w_seg = 7'h00;
            4'd9: w_seg = 7'h10;
            default: w_seg = 7'h7F;
        endcase
    end

    // Register enable and segments together so they always describe the same digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_bit <= 6'b111110;
            sm_seg <= 8'hC0;
        end else begin
            sm_bit <= ~w_sel;
            sm_seg <= {w_dp_n, w_seg};
        end
    end
endmodule

// File: tb/tb_stopwatch_top.sv
`timescale 1ns/1ps
module tb_stopwatch_top;
    logic       clk;
    logic       rst_n;
    logic       Clear;
    logic       start_stop;
    logic [5:0] sm_bit;
    logic [7:0] sm_seg;

    int checks = 0;
    int errors = 0;

    stopwatch_top #(.TICK_DIV(10), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Clear      (Clear),
        .start_stop (start_stop),
        .sm_bit     (sm_bit),
        .sm_seg     (sm_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] dut_time();
        return {dut.r_m1, dut.r_m0, dut.r_s1, dut.r_s0, dut.r_c1, dut.r_c0};
    endfunction

    function automatic logic [3:0] dec7(input logic [6:0] s);
        case (s)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    task automatic wait_run(input logic val, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dut.r_running !== val && n < 20);
    endtask

    // Collect one full scan from the pins and rebuild the six BCD digits.
    task automatic read_disp(output logic [23:0] v, output logic ok);
        logic [5:0] seen;
        logic [5:0] pat;
        logic       found;
        v    = '1;
        ok   = 1'b1;
        seen = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            found = 1'b0;
            for (int k = 0; k < 6; k++) begin
                pat = ~(6'd1 << k);
                if (sm_bit === pat) begin
                    found       = 1'b1;
                    seen[k]     = 1'b1;
                    v[4*k +: 4] = dec7(sm_seg[6:0]);
                    if (sm_seg[7] !== ((k == 2 || k == 4) ? 1'b0 : 1'b1)) ok = 1'b0;
                end
            end
            if (!found) ok = 1'b0;
        end
        if (seen != 6'h3F) ok = 1'b0;
    endtask

    initial begin
        int         n;
        int         k;
        logic [5:0] prev;
        logic [5:0] exp_bit;
        logic [23:0] v;
        logic        ok;
        logic        seen_run;

        rst_n      = 1'b0;
        Clear      = 1'b1;
        start_stop = 1'b1;

        // Reset values on the pins
        #50;
        chk("rst_sm_bit", 32'(sm_bit), 32'h3E);
        chk("rst_sm_seg", 32'(sm_seg), 32'hC0);
        #50;
        rst_n = 1'b1;

        // Scan sequence: one step every 4 clocks, dp on digits 4 and 2
        for (int s = 1; s <= 6; s++) begin
            prev = sm_bit;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (sm_bit === prev && n < 12);
            k       = s % 6;
            exp_bit = ~(6'd1 << k);
            chk("scan_bit", 32'(sm_bit), 32'(exp_bit));
            chk("scan_seg", 32'(sm_seg), (k == 2 || k == 4) ? 32'h40 : 32'hC0);
            if (s >= 2) chk("scan_dwell", 32'(n), 32'd4);
        end

        // Hold start_stop from 600 ns: start, tick every 10 cycles, no re-toggle
        while ($time < 600) @(negedge clk);
        start_stop = 1'b0;
        wait_run(1'b1, n);
        chk("press_latency", 32'(n), 32'd6);
        repeat (9) @(negedge clk);
        chk("before_first_tick", 32'(dut_time()), 32'h000000);
        @(negedge clk);
        chk("first_tick", 32'(dut_time()), 32'h000001);
        repeat (990) @(negedge clk);
        chk("hundred_ticks", 32'(dut_time()), 32'h000100);
        chk("held_no_toggle", 32'(dut.r_running), 32'd1);

        // Two-cycle glitch is rejected
        start_stop = 1'b1;
        repeat (2) @(negedge clk);
        start_stop = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_ignored", 32'(dut.r_running), 32'd1);

        // Clear while running
        Clear = 1'b0;
        repeat (8) @(negedge clk);
        chk("clr_run_running", 32'(dut.r_running), 32'd0);
        chk("clr_run_time", 32'(dut_time()), 32'h000000);
        repeat (20) @(negedge clk);
        chk("clr_run_stays", 32'(dut_time()), 32'h000000);
        Clear = 1'b1;
        repeat (8) @(negedge clk);
        start_stop = 1'b1;
        repeat (8) @(negedge clk);
        chk("release_no_toggle", 32'(dut.r_running), 32'd0);

        // Run to 00.00.37, stop mid-period, verify freeze and phase-preserving resume
        start_stop = 1'b0;
        wait_run(1'b1, n);
        chk("start2_latency", 32'(n), 32'd6);
        start_stop = 1'b1;
        repeat (369) @(negedge clk);
        chk("cs36", 32'(dut_time()), 32'h000036);
        @(negedge clk);
        chk("cs37", 32'(dut_time()), 32'h000037);
        repeat (2) @(negedge clk);
        start_stop = 1'b0;
        wait_run(1'b0, n);
        chk("stop_latency", 32'(n), 32'd6);
        repeat (30) @(negedge clk);
        chk("frozen_time", 32'(dut_time()), 32'h000037);
        read_disp(v, ok);
        chk("frozen_disp", 32'(v), 32'h000037);
        chk("frozen_disp_ok", 32'(ok), 32'd1);
        start_stop = 1'b1;
        repeat (8) @(negedge clk);
        start_stop = 1'b0;
        wait_run(1'b1, n);
        chk("resume_latency", 32'(n), 32'd6);
        @(negedge clk);
        chk("resume_pre_tick", 32'(dut_time()), 32'h000037);
        @(negedge clk);
        chk("resume_tick", 32'(dut_time()), 32'h000038);

        // Stop, then Clear while stopped
        start_stop = 1'b1;
        repeat (8) @(negedge clk);
        start_stop = 1'b0;
        wait_run(1'b0, n);
        chk("stop2_done", 32'(dut.r_running), 32'd0);
        start_stop = 1'b1;
        repeat (8) @(negedge clk);
        Clear = 1'b0;
        repeat (8) @(negedge clk);
        chk("clr_stop_running", 32'(dut.r_running), 32'd0);
        chk("clr_stop_time", 32'(dut_time()), 32'h000000);
        Clear = 1'b1;
        repeat (8) @(negedge clk);
        read_disp(v, ok);
        chk("clr_disp", 32'(v), 32'h000000);
        chk("clr_disp_ok", 32'(ok), 32'd1);

        // Clear and start_stop debounced on the same cycle: Clear wins
        Clear      = 1'b0;
        start_stop = 1'b0;
        seen_run   = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dut.r_running !== 1'b0) seen_run = 1'b1;
        end
        chk("simul_clear_wins", 32'(seen_run), 32'd0);
        Clear      = 1'b1;
        start_stop = 1'b1;
        repeat (8) @(negedge clk);

        // Preload 59.59.99 and roll over
        force dut.r_m1 = 4'd5;
        force dut.r_m0 = 4'd9;
        force dut.r_s1 = 4'd5;
        force dut.r_s0 = 4'd9;
        force dut.r_c1 = 4'd9;
        force dut.r_c0 = 4'd9;
        @(negedge clk);
        release dut.r_m1;
        release dut.r_m0;
        release dut.r_s1;
        release dut.r_s0;
        release dut.r_c1;
        release dut.r_c0;
        @(negedge clk);
        chk("preload_time", 32'(dut_time()), 32'h595999);
        read_disp(v, ok);
        chk("preload_disp", 32'(v), 32'h595999);
        start_stop = 1'b0;
        wait_run(1'b1, n);
        chk("start3_latency", 32'(n), 32'd6);
        start_stop = 1'b1;
        repeat (9) @(negedge clk);
        chk("pre_rollover", 32'(dut_time()), 32'h595999);
        @(negedge clk);
        chk("rollover", 32'(dut_time()), 32'h000000);
        repeat (10) @(negedge clk);
        chk("after_rollover", 32'(dut_time()), 32'h000001);
        chk("still_running", 32'(dut.r_running), 32'd1);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bit", 32'(sm_bit), 32'h3E);
        chk("mid_rst_seg", 32'(sm_seg), 32'hC0);
        chk("mid_rst_running", 32'(dut.r_running), 32'd0);
        chk("mid_rst_time", 32'(dut_time()), 32'h000000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_running", 32'(dut.r_running), 32'd0);
        chk("post_rst_time", 32'(dut_time()), 32'h000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
